// File: rtl/hdlc_rx_bus_master.sv
// Register-bus initiator that drains received frames from the Hdlc Rx side.
// Ready frames are streamed byte by byte. Errored or empty frames are dropped through Rx_Drop.
module hdlc_rx_bus_master #(
    parameter logic [2:0] ADDR_RXSC    = 3'h2,
    parameter logic [2:0] ADDR_RXBUFF  = 3'h3,
    parameter logic [2:0] ADDR_RXLEN   = 3'h4,
    parameter int         READ_LATENCY = 1,
    parameter int         POLL_GAP     = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    input  logic        FCSen,
    output logic [2:0]  Address,
    output logic        WriteEnable,
    output logic        ReadEnable,
    output logic [7:0]  DataIn,
    input  logic [7:0]  DataOut,
    output logic [7:0]  M_Data,
    output logic        M_Valid,
    input  logic        M_Ready,
    output logic        M_Last,
    output logic        M_Error,
    output logic [15:0] FrameCnt,
    output logic [15:0] DropCnt,
    output logic        Busy
);

    typedef enum logic [3:0] {
        IDLE, POLL_RD, POLL_WT, LEN_RD, LEN_WT, DAT_RD, DAT_WT, DAT_OUT, DROP
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);
    localparam logic [7:0] GAP_INIT  = 8'(POLL_GAP);

    state_t      state, state_nx;
    logic [7:0]  gap_cnt, gap_nx;
    logic [1:0]  wait_cnt, wait_nx;
    logic [7:0]  remaining, remaining_nx;
    logic [2:0]  addr_nx;
    logic        we_nx, re_nx, mvalid_nx, mlast_nx, merr_nx;
    logic [7:0]  din_nx, mdata_nx;
    logic [15:0] frame_nx, drop_nx;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            gap_cnt     <= 8'd0;
            wait_cnt    <= 2'd0;
            remaining   <= 8'd0;
            Address     <= 3'd0;
            WriteEnable <= 1'b0;
            ReadEnable  <= 1'b0;
            DataIn      <= 8'd0;
            M_Data      <= 8'd0;
            M_Valid     <= 1'b0;
            M_Last      <= 1'b0;
            M_Error     <= 1'b0;
            FrameCnt    <= 16'd0;
            DropCnt     <= 16'd0;
            Busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            gap_cnt     <= gap_nx;
            wait_cnt    <= wait_nx;
            remaining   <= remaining_nx;
            Address     <= addr_nx;
            WriteEnable <= we_nx;
            ReadEnable  <= re_nx;
            DataIn      <= din_nx;
            M_Data      <= mdata_nx;
            M_Valid     <= mvalid_nx;
            M_Last      <= mlast_nx;
            M_Error     <= merr_nx;
            FrameCnt    <= frame_nx;
            DropCnt     <= drop_nx;
            Busy        <= (state_nx != IDLE);
        end
    end

    // Strobes are computed one state ahead so that they show up registered during the RD/DROP states.
    always_comb begin
        state_nx     = state;
        gap_nx       = gap_cnt;
        wait_nx      = wait_cnt;
        remaining_nx = remaining;
        addr_nx      = Address;
        we_nx        = 1'b0;
        re_nx        = 1'b0;
        din_nx       = DataIn;
        mdata_nx     = M_Data;
        mvalid_nx    = M_Valid;
        mlast_nx     = M_Last;
        merr_nx      = 1'b0;
        frame_nx     = FrameCnt;
        drop_nx      = DropCnt;

        case (state)
            IDLE: begin
                // Launch on the cycle the gap would reach zero, giving exactly POLL_GAP idle cycles.
                if (Enable && gap_cnt <= 8'd1) begin
                    state_nx = POLL_RD;
                    gap_nx   = 8'd0;
                    re_nx    = 1'b1;
                    addr_nx  = ADDR_RXSC;
                end else if (gap_cnt != 8'd0) begin
                    gap_nx = gap_cnt - 8'd1;
                end
            end
            POLL_RD: begin
                state_nx = POLL_WT;
                wait_nx  = WAIT_INIT;
            end
            POLL_WT: begin
                if (wait_cnt != 2'd0) begin
                    wait_nx = wait_cnt - 2'd1;
                end else if (!DataOut[0]) begin
                    state_nx = IDLE;
                    gap_nx   = GAP_INIT;
                end else if (|DataOut[4:2]) begin
                    state_nx = DROP;
                    we_nx    = 1'b1;
                    addr_nx  = ADDR_RXSC;
                    din_nx   = {2'b00, FCSen, 3'b000, 1'b1, 1'b0};
                    merr_nx  = 1'b1;
                end else begin
                    state_nx = LEN_RD;
                    re_nx    = 1'b1;
                    addr_nx  = ADDR_RXLEN;
                end
            end
            LEN_RD: begin
                state_nx = LEN_WT;
                wait_nx  = WAIT_INIT;
            end
            LEN_WT: begin
                if (wait_cnt != 2'd0) begin
                    wait_nx = wait_cnt - 2'd1;
                end else if (DataOut == 8'd0) begin
                    state_nx = DROP;
                    we_nx    = 1'b1;
                    addr_nx  = ADDR_RXSC;
                    din_nx   = {2'b00, FCSen, 3'b000, 1'b1, 1'b0};
                    merr_nx  = 1'b1;
                end else begin
                    state_nx     = DAT_RD;
                    remaining_nx = DataOut;
                    re_nx        = 1'b1;
                    addr_nx      = ADDR_RXBUFF;
                end
            end
            DAT_RD: begin
                state_nx = DAT_WT;
                wait_nx  = WAIT_INIT;
            end
            DAT_WT: begin
                if (wait_cnt != 2'd0) begin
                    wait_nx = wait_cnt - 2'd1;
                end else begin
                    state_nx  = DAT_OUT;
                    mdata_nx  = DataOut;
                    mvalid_nx = 1'b1;
                    mlast_nx  = (remaining == 8'd1);
                end
            end
            DAT_OUT: begin
                if (M_Ready) begin
                    mvalid_nx    = 1'b0;
                    mlast_nx     = 1'b0;
                    remaining_nx = remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        state_nx = IDLE;
                        frame_nx = FrameCnt + 16'd1;
                        gap_nx   = GAP_INIT;
                    end else begin
                        state_nx = DAT_RD;
                        re_nx    = 1'b1;
                        addr_nx  = ADDR_RXBUFF;
                    end
                end
            end
            DROP: begin
                state_nx = IDLE;
                drop_nx  = DropCnt + 16'd1;
                gap_nx   = GAP_INIT;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hdlc_rx_bus_master.sv
// Directed testbench for hdlc_rx_bus_master against a small Hdlc Rx register model.
// Each scenario task drives stimulus and checks its own expectations.
module tb_hdlc_rx_bus_master;

    localparam logic [2:0] A_SC  = 3'h2;
    localparam logic [2:0] A_BUF = 3'h3;
    localparam logic [2:0] A_LEN = 3'h4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Enable = 1'b0;
    logic        FCSen = 1'b0;
    logic        M_Ready = 1'b0;
    logic [7:0]  DataOut = 8'h00;
    logic [2:0]  Address;
    logic        WriteEnable, ReadEnable, M_Valid, M_Last, M_Error, Busy;
    logic [7:0]  DataIn, M_Data;
    logic [15:0] FrameCnt, DropCnt;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_frame = 0;
    int exp_drop = 0;

    logic [7:0] inj_sc = 8'h00;
    logic [7:0] inj_len = 8'h00;
    logic [7:0] inj_buf[$];
    int         inj_id = 0;
    logic [7:0] sc_reg = 8'h00;
    logic [7:0] len_reg = 8'h00;
    logic [7:0] buf_q[$];
    logic [7:0] pop_byte;
    int         seen_id = 0;
    int rd_len = 0, rd_buf = 0, wr_cnt = 0;
    int both_cnt = 0, re_long = 0, we_long = 0, mvalid_cnt = 0;
    logic prev_re = 1'b0, prev_we = 1'b0;

    logic [7:0] cap_data[$];
    logic       cap_last[$];

    hdlc_rx_bus_master dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .FCSen(FCSen),
        .Address(Address), .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
        .DataIn(DataIn), .DataOut(DataOut),
        .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready), .M_Last(M_Last),
        .M_Error(M_Error), .FrameCnt(FrameCnt), .DropCnt(DropCnt), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Hdlc Rx register model with one cycle read latency. Reading the last buffer byte or an Rx_Drop write clears Rx_Ready.
    always @(posedge Clk) begin
        if (inj_id != seen_id) begin
            seen_id = inj_id;
            sc_reg  = inj_sc;
            len_reg = inj_len;
            buf_q   = inj_buf;
        end
        if (ReadEnable === 1'b1) begin
            case (Address)
                A_SC:  DataOut <= sc_reg;
                A_LEN: begin DataOut <= len_reg; rd_len++; end
                A_BUF: begin
                    rd_buf++;
                    pop_byte = 8'h00;
                    if (buf_q.size() > 0) pop_byte = buf_q.pop_front();
                    DataOut <= pop_byte;
                    if (buf_q.size() == 0) sc_reg = 8'h00;
                end
                default: DataOut <= 8'hEE;
            endcase
        end
        if (WriteEnable === 1'b1) begin
            wr_cnt++;
            if (Address == A_SC && DataIn[1]) sc_reg = 8'h00;
        end
    end

    always @(negedge Clk) begin
        if (ReadEnable === 1'b1 && WriteEnable === 1'b1) both_cnt++;
        if (ReadEnable === 1'b1 && prev_re) re_long++;
        if (WriteEnable === 1'b1 && prev_we) we_long++;
        if (M_Valid === 1'b1) mvalid_cnt++;
        prev_re = (ReadEnable === 1'b1);
        prev_we = (WriteEnable === 1'b1);
    end

    // Drives M_Ready on each negedge and records handshakes. Also counts cycles where a stalled byte changed.
    task automatic stream_frame(input int stop_at, input bit rand_ready, input int max_cycles,
                                output int got, output int stall_bad);
        logic [7:0] hold_d = 8'h00;
        logic       hold_l = 1'b0;
        bit         stalled = 1'b0;
        got = 0;
        stall_bad = 0;
        cap_data.delete();
        cap_last.delete();
        for (int c = 0; c < max_cycles && got < stop_at; c++) begin
            @(negedge Clk);
            if (stalled && (M_Valid !== 1'b1 || M_Data !== hold_d || M_Last !== hold_l)) stall_bad++;
            M_Ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (M_Valid === 1'b1) begin
                if (M_Ready) begin
                    cap_data.push_back(M_Data);
                    cap_last.push_back(M_Last);
                    got++;
                end else begin
                    stalled = 1'b1;
                    hold_d  = M_Data;
                    hold_l  = M_Last;
                end
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0; Enable = 1'b1; FCSen = 1'b0; M_Ready = 1'b1;
        repeat (3) @(negedge Clk);
        tests_run++;
        if ({Address, WriteEnable, ReadEnable, DataIn} !== 13'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bus: got %h expected 0", {Address, WriteEnable, ReadEnable, DataIn});
        end
        tests_run++;
        if ({M_Data, M_Valid, M_Last, M_Error, Busy} !== 12'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_stream: got %h expected 0", {M_Data, M_Valid, M_Last, M_Error, Busy});
        end
        tests_run++;
        if ({FrameCnt, DropCnt} !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_counters: got %h expected 0", {FrameCnt, DropCnt});
        end
        Rst = 1'b1;
        #1;
        tests_run++;
        if (ReadEnable !== 1'b0 || WriteEnable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL release_no_access: got re=%b we=%b expected 0 0", ReadEnable, WriteEnable);
        end
    endtask

    task automatic test_polling();
        int pulses = 0, last = 0, per_bad = 0, addr_bad = 0, we_seen = 0, mv_seen = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clk);
            if (ReadEnable === 1'b1) begin
                pulses++;
                if (Address !== A_SC) addr_bad++;
                if (last != 0 && c - last != 6) per_bad++;
                last = c;
            end
            if (WriteEnable !== 1'b0) we_seen++;
            if (M_Valid !== 1'b0) mv_seen++;
        end
        tests_run++;
        if (pulses !== 5) begin tests_failed++; $display("[TB] FAIL poll_count: got %0d expected 5", pulses); end
        tests_run++;
        if (per_bad !== 0) begin tests_failed++; $display("[TB] FAIL poll_period: got %0d bad gaps expected 0", per_bad); end
        tests_run++;
        if (addr_bad !== 0) begin tests_failed++; $display("[TB] FAIL poll_addr: got %0d bad expected 0", addr_bad); end
        tests_run++;
        if (we_seen + mv_seen !== 0) begin
            tests_failed++;
            $display("[TB] FAIL poll_quiet: got we=%0d valid=%0d expected 0 0", we_seen, mv_seen);
        end
    endtask

    task automatic test_frame(input bit rand_ready, input string name);
        int got, stall_bad, buf0, len0;
        logic [31:0] word = 32'h0;
        logic [3:0]  lasts = 4'h0;
        buf0 = rd_buf; len0 = rd_len;
        inj_buf = '{8'hA5, 8'h01, 8'hFF, 8'h7E};
        inj_sc = 8'h01; inj_len = 8'd4; inj_id++;
        stream_frame(4, rand_ready, 400, got, stall_bad);
        M_Ready = 1'b1;
        @(negedge Clk);
        exp_frame++;
        for (int i = 0; i < cap_data.size() && i < 4; i++) begin
            word[31 - 8*i -: 8] = cap_data[i];
            lasts[3 - i] = cap_last[i];
        end
        tests_run++;
        if (got !== 4) begin tests_failed++; $display("[TB] FAIL %s_count: got %0d expected 4", name, got); end
        tests_run++;
        if (word !== 32'hA501FF7E) begin tests_failed++; $display("[TB] FAIL %s_bytes: got %h expected a501ff7e", name, word); end
        tests_run++;
        if (lasts !== 4'b0001) begin tests_failed++; $display("[TB] FAIL %s_last: got %b expected 0001", name, lasts); end
        tests_run++;
        if (stall_bad !== 0) begin tests_failed++; $display("[TB] FAIL %s_stall_stable: got %0d changes expected 0", name, stall_bad); end
        tests_run++;
        if (rd_buf - buf0 !== 4 || rd_len - len0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL %s_reads: got buf=%0d len=%0d expected 4 1", name, rd_buf - buf0, rd_len - len0);
        end
        tests_run++;
        if (FrameCnt !== 16'(exp_frame)) begin tests_failed++; $display("[TB] FAIL %s_framecnt: got %0d expected %0d", name, FrameCnt, exp_frame); end
    endtask

    task automatic test_drop(input logic [7:0] sc, input logic [7:0] len, input logic fcs,
                             input logic [7:0] exp_din, input int exp_len_rd, input string name);
        int wr0, len0, buf0, mv0;
        bit seen = 1'b0;
        logic [11:0] strobe = 12'h0;
        FCSen = fcs;
        wr0 = wr_cnt; len0 = rd_len; buf0 = rd_buf; mv0 = mvalid_cnt;
        inj_buf = '{8'h11, 8'h22, 8'h33};
        inj_sc = sc; inj_len = len; inj_id++;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge Clk);
            if (M_Error === 1'b1) begin
                seen = 1'b1;
                strobe = {WriteEnable, Address, DataIn};
            end
        end
        @(negedge Clk);
        exp_drop++;
        tests_run++;
        if (!seen || strobe !== {1'b1, A_SC, exp_din}) begin
            tests_failed++;
            $display("[TB] FAIL %s_write: got seen=%0d we/addr/data=%h expected %h", name, seen, strobe, {1'b1, A_SC, exp_din});
        end
        tests_run++;
        if (M_Error !== 1'b0 || wr_cnt - wr0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL %s_single: got merr=%b writes=%0d expected 0 1", name, M_Error, wr_cnt - wr0);
        end
        tests_run++;
        if (rd_len - len0 !== exp_len_rd || rd_buf - buf0 !== 0 || mvalid_cnt - mv0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_no_stream: got len_rd=%0d buf_rd=%0d valid=%0d expected %0d 0 0",
                     name, rd_len - len0, rd_buf - buf0, mvalid_cnt - mv0, exp_len_rd);
        end
        tests_run++;
        if (DropCnt !== 16'(exp_drop) || FrameCnt !== 16'(exp_frame)) begin
            tests_failed++;
            $display("[TB] FAIL %s_counts: got drop=%0d frame=%0d expected %0d %0d", name, DropCnt, FrameCnt, exp_drop, exp_frame);
        end
    endtask

    task automatic test_long_frame();
        int got, stall_bad, buf0, data_bad = 0, last_bad = 0;
        buf0 = rd_buf;
        inj_buf.delete();
        for (int i = 0; i < 126; i++) inj_buf.push_back(8'(i * 7 + 3));
        inj_sc = 8'h01; inj_len = 8'd126; inj_id++;
        stream_frame(126, 1'b0, 2000, got, stall_bad);
        @(negedge Clk);
        exp_frame++;
        for (int i = 0; i < cap_data.size(); i++) begin
            if (cap_data[i] !== 8'(i * 7 + 3)) data_bad++;
            if (cap_last[i] !== (i == 125)) last_bad++;
        end
        tests_run++;
        if (got !== 126 || rd_buf - buf0 !== 126) begin
            tests_failed++;
            $display("[TB] FAIL long_count: got %0d bytes %0d reads expected 126 126", got, rd_buf - buf0);
        end
        tests_run++;
        if (data_bad + last_bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL long_bytes: got %0d data %0d last errors expected 0", data_bad, last_bad);
        end
        tests_run++;
        if (FrameCnt !== 16'(exp_frame) || DropCnt !== 16'(exp_drop)) begin
            tests_failed++;
            $display("[TB] FAIL long_counts: got frame=%0d drop=%0d expected %0d %0d", FrameCnt, DropCnt, exp_frame, exp_drop);
        end
    endtask

    task automatic test_reset_mid_frame();
        int got, stall_bad;
        bit polled = 1'b0;
        inj_buf.delete();
        for (int i = 0; i < 20; i++) inj_buf.push_back(8'(8'h40 + i));
        inj_sc = 8'h01; inj_len = 8'd20; inj_id++;
        stream_frame(10, 1'b0, 500, got, stall_bad);
        #2 Rst = 1'b0;
        #1;
        tests_run++;
        if (got !== 10 || {Address, WriteEnable, ReadEnable, DataIn, M_Data, M_Valid, M_Last, M_Error, Busy} !== 25'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: got bytes=%0d outs=%h expected 10 0", got,
                     {Address, WriteEnable, ReadEnable, DataIn, M_Data, M_Valid, M_Last, M_Error, Busy});
        end
        tests_run++;
        if ({FrameCnt, DropCnt} !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_counters: got %h expected 0", {FrameCnt, DropCnt});
        end
        inj_buf.delete();
        inj_sc = 8'h00; inj_len = 8'h00; inj_id++;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        exp_frame = 0;
        exp_drop = 0;
        for (int c = 0; c < 12 && !polled; c++) begin
            @(negedge Clk);
            if (ReadEnable === 1'b1 && Address === A_SC) polled = 1'b1;
        end
        tests_run++;
        if (!polled) begin tests_failed++; $display("[TB] FAIL midreset_poll: got no poll expected poll within 12 cycles"); end
        inj_buf = '{8'h3C, 8'hC3};
        inj_sc = 8'h01; inj_len = 8'd2; inj_id++;
        stream_frame(2, 1'b0, 200, got, stall_bad);
        @(negedge Clk);
        exp_frame++;
        tests_run++;
        if (got !== 2 || FrameCnt !== 16'(exp_frame) || DropCnt !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_restart: got bytes=%0d frame=%0d drop=%0d expected 2 1 0", got, FrameCnt, DropCnt);
        end
    endtask

    task automatic test_strobes();
        tests_run++;
        if (both_cnt !== 0) begin tests_failed++; $display("[TB] FAIL strobe_exclusive: got %0d overlaps expected 0", both_cnt); end
        tests_run++;
        if (re_long + we_long !== 0) begin
            tests_failed++;
            $display("[TB] FAIL strobe_width: got re=%0d we=%0d long expected 0 0", re_long, we_long);
        end
    endtask

    initial begin
        test_reset();
        test_polling();
        test_frame(1'b0, "frame_ready");
        test_frame(1'b1, "frame_stall");
        test_drop(8'h05, 8'd3, 1'b1, 8'h22, 0, "fcs_drop");
        test_drop(8'h09, 8'd3, 1'b0, 8'h02, 0, "abort_drop");
        test_drop(8'h11, 8'd3, 1'b1, 8'h22, 0, "overflow_drop");
        test_drop(8'h01, 8'd0, 1'b0, 8'h02, 1, "zero_len_drop");
        test_long_frame();
        test_reset_mid_frame();
        test_strobes();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
